pid_for_verilog: RTL and testbench



---
 rtl/pid_for_verilog.sv | 102 ++++++++++
 tb/tb_pid_for_verilog.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_for_verilog.sv
// Fixed-point Q16.16 PID controller with saturating arithmetic and clock enable.
// Define PID_DERIV_EN to build the derivative path (e_prev register, KD term).
module pid_for_verilog #(
  parameter logic signed [31:0] KP      = 32'sh0001_0000,
  parameter logic signed [31:0] KI      = 32'sh0000_0000,
  parameter logic signed [31:0] KD      = 32'sh0000_0000,
  parameter logic signed [31:0] INT_LIM = 32'sh7FFF_FFFF,
  parameter logic signed [31:0] OUT_MAX = 32'sh7FFF_FFFF,
  parameter logic signed [31:0] OUT_MIN = 32'sh8000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [11:0] Sensor,
  input  logic signed [31:0] SetPoint,
  output logic               ce_out,
  output logic signed [31:0] out
);

  function automatic logic signed [31:0] clamp(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    logic signed [63:0] r;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    return r[31:0];
  endfunction

  function automatic logic signed [31:0] sat(
    input logic signed [63:0] v
  );
    return clamp(v, 64'shFFFF_FFFF_8000_0000,
                 64'sh0000_0000_7FFF_FFFF);
  endfunction

  function automatic logic signed [31:0] gain(
    input logic signed [31:0] g,
    input logic signed [31:0] x
  );
    logic signed [63:0] p;
    p = 64'(g) * 64'(x);
    return sat(p >>> 16);
  endfunction

  logic signed [31:0] sens_q;
  logic signed [31:0] e;
  logic signed [31:0] i_acc;
  logic signed [31:0] i_next;
  logic signed [31:0] p_term;
  logic signed [31:0] i_term;
  logic signed [31:0] d_term;
  logic signed [31:0] sum;
  logic signed [31:0] out_next;

  assign ce_out = clk_enable;
  assign sens_q = {{4{Sensor[11]}}, Sensor, 16'h0000};

  always_comb begin
    e      = sat(64'(SetPoint) - 64'(sens_q));
    i_next = clamp(64'(i_acc) + 64'(e),
                   -64'(INT_LIM), 64'(INT_LIM));
    p_term = gain(KP, e);
    i_term = gain(KI, i_next);
  end

`ifdef PID_DERIV_EN
  logic signed [31:0] e_prev;
  logic signed [31:0] d;

  always_comb begin
    d      = sat(64'(e) - 64'(e_prev));
    d_term = gain(KD, d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_prev <= '0;
    else if (clk_enable) e_prev <= e;
  end
`else
  // No derivative state: KD multiplies a constant zero
  assign d_term = gain(KD, 32'sd0);
`endif

  always_comb begin
    sum      = sat(64'(p_term) + 64'(i_term) + 64'(d_term));
    out_next = clamp(64'(sum), 64'(OUT_MIN), 64'(OUT_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out   <= '0;
      i_acc <= '0;
    end else if (clk_enable) begin
      out   <= out_next;
      i_acc <= i_next;
    end
  end

endmodule

// File: tb/tb_pid_for_verilog.sv
// Bench for pid_for_verilog: six parameter sets share one stimulus stream,
// checked every cycle against an arithmetic model plus literal spot values.
module tb_pid_for_verilog;

`ifdef PID_DERIV_EN
  localparam bit DERIV = 1'b1;
  localparam logic [31:0] D1 = 32'h03E8_0000;
`else
  localparam bit DERIV = 1'b0;
  localparam logic [31:0] D1 = 32'h0000_0000;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clk_enable = 1'b1;
  logic signed [11:0] Sensor = '0;
  logic signed [31:0] SetPoint = '0;
  logic [31:0]        outv [6];
  logic               ce [6];
  bit                 run = 1'b0;
  int                 checks = 0;
  int                 errors = 0;

  // 0 P, 1 P+I, 2 huge KP, 3 huge KP + OUT_MAX, 4 D, 5 I with INT_LIM/OUT_MIN
  int kp [6] = '{32'sh0001_0000, 32'sh0001_0000, 32'sh7FFF_FFFF,
                 32'sh7FFF_FFFF, 0, 0};
  int ki [6] = '{0, 32'sh0001_0000, 0, 0, 0, 32'sh0001_0000};
  int kd [6] = '{0, 0, 0, 0, 32'sh0001_0000, 0};
  int il [6] = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF,
                 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh0BB8_0000};
  int omx [6] = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF,
                  32'sh0064_0000, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
  int omn [6] = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000,
                  32'sh8000_0000, 32'sh8000_0000, 32'shFFF0_0000};

  always #5 clk = ~clk;

  pid_for_verilog #(.KP(32'sh0001_0000)) u_p (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[0]), .out(outv[0]));
  pid_for_verilog #(.KP(32'sh0001_0000), .KI(32'sh0001_0000)) u_i (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[1]), .out(outv[1]));
  pid_for_verilog #(.KP(32'sh7FFF_FFFF)) u_s (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[2]), .out(outv[2]));
  pid_for_verilog #(.KP(32'sh7FFF_FFFF), .OUT_MAX(32'sh0064_0000)) u_o (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[3]), .out(outv[3]));
  pid_for_verilog #(.KP(32'sh0), .KD(32'sh0001_0000)) u_d (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[4]), .out(outv[4]));
  pid_for_verilog #(.KP(32'sh0), .KI(32'sh0001_0000),
                    .INT_LIM(32'sh0BB8_0000), .OUT_MIN(32'shFFF0_0000)) u_l (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .Sensor(Sensor),
    .SetPoint(SetPoint), .ce_out(ce[5]), .out(outv[5]));

  function automatic longint clampl(input longint v, input longint lo,
                                    input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sat(input longint v);
    return clampl(v, -64'sd2147483648, 64'sd2147483647);
  endfunction

  function automatic longint mulq(input longint g, input longint x);
    return sat((g * x) >>> 16);
  endfunction

  longint mi [6] = '{default: 0};
  longint me [6] = '{default: 0};
  longint mo [6] = '{default: 0};

  function automatic void step(input int k, input longint i0,
                               input longint ep, input longint sn,
                               input longint sp, output longint i1,
                               output longint e, output longint o);
    longint d;
    e  = sat(sp - sn * 65536);
    i1 = clampl(i0 + e, -longint'(il[k]), longint'(il[k]));
    d  = DERIV ? sat(e - ep) : 64'sd0;
    o  = clampl(sat(mulq(kp[k], e) + mulq(ki[k], i1) + mulq(kd[k], d)),
                longint'(omn[k]), longint'(omx[k]));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 6; k++) begin
        mi[k] <= 0;
        me[k] <= 0;
        mo[k] <= 0;
      end
    end else if (clk_enable) begin
      for (int k = 0; k < 6; k++) begin
        longint i1, e, o;
        step(k, mi[k], me[k], longint'(Sensor), longint'(SetPoint),
             i1, e, o);
        mi[k] <= i1;
        me[k] <= e;
        mo[k] <= o;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (outv[k] !== mo[k][31:0]) begin
          errors++;
          $display("FAIL model_out[%0d] got %h want %h t=%0t",
                   k, outv[k], mo[k][31:0], $time);
        end
        checks++;
        if (ce[k] !== clk_enable) begin
          errors++;
          $display("FAIL ce_out[%0d] got %b want %b", k, ce[k], clk_enable);
        end
      end
    end
  end

  task automatic lit(input string n, input int k, input logic [31:0] w);
    checks++;
    if (outv[k] !== w) begin
      errors++;
      $display("FAIL %s got %h want %h", n, outv[k], w);
    end
  endtask

  logic signed [11:0] vs [6] = '{-12'sd2048, 12'sd5, -12'sd3, -12'sd3,
                                 12'sd100, 12'sd0};
  logic signed [31:0] vp [6] = '{32'sh7FFF_FFFF, 32'sh0005_8000,
                                 32'shFFF0_0000, 32'shFFF0_0000,
                                 32'sh0000_0000, 32'sh0000_0000};
  bit vn [6] = '{1, 1, 0, 1, 1, 1};

  initial begin
    reset = 1'b0;
    run = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset_p", 0, 32'h0);
    lit("reset_i", 1, 32'h0);
    #1;
    Sensor = 12'sd1000;
    SetPoint = 32'sh07D0_0000;
    reset = 1'b1;
    @(negedge clk);
    lit("p_first", 0, 32'h03E8_0000);
    lit("i_step1", 1, 32'h07D0_0000);
    lit("kp_sat", 2, 32'h7FFF_FFFF);
    lit("out_max", 3, 32'h0064_0000);
    lit("d_step", 4, D1);
    lit("lim_step1", 5, 32'h03E8_0000);
    @(negedge clk);
    lit("p_hold", 0, 32'h03E8_0000);
    lit("i_step2", 1, 32'h0BB8_0000);
    lit("d_after", 4, 32'h0);
    @(negedge clk);
    lit("i_step3", 1, 32'h0FA0_0000);
    lit("int_lim", 5, 32'h0BB8_0000);
    #1 clk_enable = 1'b0;
    repeat (4) @(negedge clk);
    lit("i_frozen", 1, 32'h0FA0_0000);
    #1 clk_enable = 1'b1;
    @(negedge clk);
    lit("i_resume", 1, 32'h1388_0000);
    lit("lim_hold", 5, 32'h0BB8_0000);
    #2 reset = 1'b0;
    #1;
    lit("async_i", 1, 32'h0);
    lit("async_p", 0, 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    lit("i_restart", 1, 32'h07D0_0000);
    #1;
    Sensor = 12'sd2047;
    SetPoint = 32'sh8000_0000;
    @(negedge clk);
    lit("e_sat", 0, 32'h8000_0000);
    lit("out_min", 5, 32'hFFF0_0000);
    for (int v = 0; v < 6; v++) begin
      #1;
      Sensor = vs[v];
      SetPoint = vp[v];
      clk_enable = vn[v];
      @(negedge clk);
    end
    #1 clk_enable = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
